// File: rtl/instruction_decoder.sv
// Instruction decoder with a small decoded-record queue.
// Each accepted MIPS word is decoded into a full record as it is written.
// The head record is presented on the out_* ports with a valid/ready handshake.
module instruction_decoder #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int WORD_WIDTH    = 32,  // only 32 is supported
   parameter int DEPTH         = 2    // 2 or 4
) (
   input  logic                     clk,
   input  logic                     reset,      // asynchronous, active-low
   input  logic                     in_valid,
   input  logic [WORD_WIDTH-1:0]    in_opcode,
   input  logic [ADDRESS_WIDTH-1:0] in_ip,
   output logic                     in_ready,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_class,
   output logic [5:0]               out_op,
   output logic [4:0]               out_rs,
   output logic [4:0]               out_rt,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_shamt,
   output logic [5:0]               out_funct,
   output logic [31:0]              out_imm,
   output logic [ADDRESS_WIDTH-1:0] out_jump,
   output logic [ADDRESS_WIDTH-1:0] out_ip
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      CLS_R   = 2'd0,
      CLS_I   = 2'd1,
      CLS_J   = 2'd2,
      CLS_ILL = 2'd3
   } insn_class_e;

   typedef struct packed {
      insn_class_e              cls;
      logic [5:0]               op;
      logic [4:0]               rs;
      logic [4:0]               rt;
      logic [4:0]               rd;
      logic [4:0]               shamt;
      logic [5:0]               funct;
      logic [31:0]              imm;
      logic [ADDRESS_WIDTH-1:0] jump;
      logic [ADDRESS_WIDTH-1:0] ip;
   } rec_t;

   rec_t               mem_q [DEPTH];
   rec_t               rec_d;
   rec_t               head;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ADDRESS_WIDTH-1:0] ip_plus4;
   logic               push;
   logic               pop;

   // Circular pointer advance, wrapping modulo DEPTH.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Handshake: in_ready never looks at out_ready, so a full queue refuses input
   // even on an edge where it also pops.
   assign in_ready  = reset && !flush && (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   assign ip_plus4  = in_ip + ADDRESS_WIDTH'(4);

   // Decode the incoming word into a full record.
   always_comb begin
      // NOTE: every field gets a default first so no path leaves a latch behind.
      rec_d       = '0;
      rec_d.op    = in_opcode[31:26];
      rec_d.rs    = in_opcode[25:21];
      rec_d.rt    = in_opcode[20:16];
      rec_d.rd    = in_opcode[15:11];
      rec_d.shamt = in_opcode[10:6];
      rec_d.funct = in_opcode[5:0];
      rec_d.ip    = in_ip;

      unique case (in_opcode[31:26])
         6'h00:                      rec_d.cls = CLS_R;
         6'h02, 6'h03:               rec_d.cls = CLS_J;
         6'h04, 6'h05, 6'h08, 6'h09,
         6'h0A, 6'h0B, 6'h0C, 6'h0D,
         6'h0E, 6'h0F, 6'h20, 6'h21,
         6'h23, 6'h24, 6'h25, 6'h28,
         6'h29, 6'h2B:               rec_d.cls = CLS_I;
         default:                    rec_d.cls = CLS_ILL;
      endcase

      unique case (in_opcode[31:26])
         6'h0C, 6'h0D, 6'h0E: rec_d.imm = {16'h0000, in_opcode[15:0]};
         6'h0F:               rec_d.imm = {in_opcode[15:0], 16'h0000};
         default:             rec_d.imm = {{16{in_opcode[15]}}, in_opcode[15:0]};
      endcase

      // Region bits of ip+4 kept, low 28 bits replaced by target26 and 2'b00.
      rec_d.jump       = ip_plus4;
      rec_d.jump[27:0] = {in_opcode[25:0], 2'b00};
   end

   // Next-state for pointers and count; flush wins over push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Record storage written on push.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; count_q alone decides which entries are live.
      if (push) mem_q[wr_ptr_q] <= rec_d;
   end

   // Head record, forced to zero while reset is asserted.
   always_comb begin
      head = reset ? mem_q[rd_ptr_q] : '0;
   end

   assign out_class = head.cls;
   assign out_op    = head.op;
   assign out_rs    = head.rs;
   assign out_rt    = head.rt;
   assign out_rd    = head.rd;
   assign out_shamt = head.shamt;
   assign out_funct = head.funct;
   assign out_imm   = head.imm;
   assign out_jump  = head.jump;
   assign out_ip    = head.ip;

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, opcode word width; only 32 is supported.
REQ-003 SHALL have parameter DEPTH, default 2, number of decoded-record queue entries; allowed values 2 or 4.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream fetch stage presents a complete opcode word.
REQ-007 SHALL have port in_opcode  input  WORD_WIDTH  fetched instruction word, MIPS encoding, bit 31 = MSB.
REQ-008 SHALL have port in_ip  input  ADDRESS_WIDTH  address of the instruction in in_opcode.
REQ-009 SHALL have port in_ready  output  1  decoder can accept a word this cycle.
REQ-010 SHALL have port flush  input  1  synchronous discard of all queued records.
REQ-011 SHALL have port out_valid  output  1  head record is valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes head record.
REQ-013 SHALL have port out_class  output  2  0=R-type, 1=I-type, 2=J-type, 3=illegal.
REQ-014 SHALL have ports out_op, out_funct (6 bits each) and out_rs, out_rt, out_rd, out_shamt (5 bits each), all outputs carrying raw instruction fields.
REQ-015 SHALL have port out_imm  output  32  extended immediate.
REQ-016 SHALL have port out_jump  output  ADDRESS_WIDTH  absolute jump target.
REQ-017 SHALL have port out_ip  output  ADDRESS_WIDTH  address of the head instruction.

Function
REQ-018 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1; no word is accepted otherwise.
REQ-019 SHALL drive in_ready=1 iff the entry count < DEPTH and flush=0.
REQ-020 SHALL decode at write time and store the full record, giving latency 1: a word accepted at edge N shows out_valid=1 after edge N.
REQ-021 SHALL pop the head record on an edge where out_valid=1 and out_ready=1.
REQ-022 SHALL perform push and pop on the same edge when both occur, leaving the count unchanged; with an empty queue the pushed record becomes the head.
REQ-023 SHALL hold every out_* value stable while out_valid=1 and out_ready=0.
REQ-024 SHALL use circular read/write pointers that wrap modulo DEPTH, plus a count of 0..DEPTH.
REQ-025 SHALL drive out_valid=1 iff count > 0; contents of the out_* data ports are don't-care while out_valid=0.
REQ-026 SHALL classify op=0x00 as R; op 0x02 and 0x03 as J; op in {04,05,08,09,0A,0B,0C,0D,0E,0F,20,21,23,24,25,28,29,2B} (hex) as I; any other op as illegal (class 3), with the record still queued.
REQ-027 SHALL set out_imm to zero-extended imm16 for op 0C/0D/0E, to {imm16,16'h0000} for op 0F, and to sign-extended imm16 for every other op.
REQ-028 SHALL compute out_jump = {upper 4 bits of (in_ip+4), target26, 2'b00}, with in_ip+4 wrapping modulo 2^ADDRESS_WIDTH.
REQ-029 SHALL, on flush=1 at an edge, clear count and both pointers and accept nothing; flush overrides both push and pop on that edge.
REQ-030 SHALL NOT let in_ready depend combinationally on out_ready; a full queue refuses input even when it pops on the same edge.

Reset
REQ-031 SHALL, while reset=0, immediately clear count and both pointers, drive out_valid=0, and drive in_ready=0.
REQ-032 SHALL force all out_* data ports to 0 during reset.
REQ-033 SHALL, on reset assertion mid-transfer, drop all queued records; no record is delivered after reset is released.
REQ-034 SHALL, on the first edge after reset is released, drive in_ready=1.

Verification
REQ-035 SHALL cover: accept 0x8C8A0010 at ip 0x100 -> next cycle class=1, op=0x23, rs=4, rt=10, imm=0x00000010, out_ip=0x100.
REQ-036 SHALL cover: accept 0x3421FFFF (ORI) -> out_imm=0x0000FFFF; accept 0x2021FFFF (ADDI) -> out_imm=0xFFFFFFFF; accept 0x3C011234 (LUI) -> out_imm=0x12340000.
REQ-037 SHALL cover: accept 0x0C000040 at ip 0xF0000000 -> class=2, out_jump=0xF0000100.
REQ-038 SHALL cover: out_ready=0 with 3 words offered at DEPTH=2 -> in_ready=0 after 2 accepts; then out_ready=1 -> records emerge in order, with pointer wrap exercised over 5+ words.
REQ-039 SHALL cover: queue holding 2 records with flush=1 and in_valid=1 on the same edge -> out_valid=0 after the edge and the offered word is not taken; also an illegal word 0xFC000000 -> class=3.
REQ-040 SHALL cover: reset=0 pulsed between edges while records are queued -> out_valid falls immediately; after release the queue is empty.
